// File: rtl/genius_pkg.sv
// genius_pkg: shared state encoding, LFSR constants and symbol helper for the round controller
package genius_pkg;
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GEN      = 3'd1,
      SHOW_ON  = 3'd2,
      SHOW_OFF = 3'd3,
      WAIT_IN  = 3'd4,
      WIN      = 3'd5,
      LOSE     = 3'd6
   } state_t;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;
   localparam logic [7:0] DEFAULT_SEED = 8'hA5;
   localparam int SYM_W = 2;
   function automatic logic [SYM_W-1:0] symbol_of(input logic [7:0] s);
      return s[SYM_W-1:0];
   endfunction
endpackage

// File: rtl/genius_round_ctrl_if.sv
// genius_round_ctrl_if: game-control and display bus between the round controller and its neighbours
interface genius_round_ctrl_if;
   logic       start;
   logic [7:0] seed;
   logic       btn_valid;
   logic [1:0] btn_code;
   logic       lamp_on;
   logic [1:0] lamp_code;
   logic [3:0] level;
   logic [3:0] step;
   logic [2:0] state;
   logic       win;
   logic       lose;
   modport master (output start, seed, btn_valid, btn_code,
                   input lamp_on, lamp_code, level, step, state, win, lose);
   modport slave (input start, seed, btn_valid, btn_code,
                  output lamp_on, lamp_code, level, step, state, win, lose);
endinterface

// File: rtl/genius_lfsr8.sv
// genius_lfsr8: 8-bit Fibonacci LFSR symbol source; a zero seed falls back to the default seed
module genius_lfsr8
   import genius_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic       advance,
   input  logic [7:0] seed,
   output logic [7:0] q
);
   always_ff @(posedge clock or negedge reset)
      if (!reset) q <= DEFAULT_SEED;
      else if (load) q <= seed == 8'h00 ? DEFAULT_SEED : seed;
      else if (advance) q <= {q[6:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/genius_round_ctrl.sv
// genius_round_ctrl: Simon round sequencer - grows the pattern, plays it back, checks presses under timeout
module genius_round_ctrl
   import genius_pkg::*;
#(
   parameter int ON_CYCLES      = 25_000_000,
   parameter int OFF_CYCLES     = 12_500_000,
   parameter int TIMEOUT_CYCLES = 250_000_000,
   parameter int MAX_LEVEL      = 16
) (
   input logic clock,
   input logic reset,
   genius_round_ctrl_if.slave bus
);
   localparam int MAXC = ON_CYCLES > OFF_CYCLES ? (ON_CYCLES > TIMEOUT_CYCLES ? ON_CYCLES : TIMEOUT_CYCLES)
                                                : (OFF_CYCLES > TIMEOUT_CYCLES ? OFF_CYCLES : TIMEOUT_CYCLES);
   localparam int TW = MAXC > 2 ? $clog2(MAXC) : 1;
   localparam logic [TW-1:0] ON_T = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0] OFF_T = TW'(OFF_CYCLES - 1);
   localparam logic [TW-1:0] TO_T = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0] LAST = 4'(MAX_LEVEL - 1);
   state_t st, st_n;
   logic [TW-1:0] tmr, tmr_n;
   logic [3:0] lvl, lvl_n, stp, stp_n, stp_inc;
   logic [1:0] code_q, code_n, sym;
   logic lamp_q, lamp_n, win_q, win_n, lose_q, lose_n, adv;
   logic [1:0] mem [16];
   logic [7:0] lfsr;
   assign sym = symbol_of(lfsr);
   assign stp_inc = stp + 4'd1;
   assign adv = st == GEN && !bus.start;
   genius_lfsr8 u_lfsr (
      .clock(clock), .reset(reset), .load(bus.start), .advance(adv), .seed(bus.seed), .q(lfsr)
   );
   always_ff @(posedge clock)
      if (adv) mem[lvl] <= sym;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         st <= IDLE;
         tmr <= '0;
         lvl <= '0;
         stp <= '0;
         lamp_q <= 1'b0;
         code_q <= '0;
         win_q <= 1'b0;
         lose_q <= 1'b0;
      end else begin
         st <= st_n;
         tmr <= tmr_n;
         lvl <= lvl_n;
         stp <= stp_n;
         lamp_q <= lamp_n;
         code_q <= lamp_n ? code_n : 2'd0;
         win_q <= win_n;
         lose_q <= lose_n;
      end
   always_comb begin
      st_n = st;
      tmr_n = tmr + TW'(1);
      lvl_n = lvl;
      stp_n = stp;
      code_n = code_q;
      if (bus.start) begin
         st_n = GEN;
         lvl_n = '0;
         stp_n = '0;
      end else
         case (st)
            GEN: begin
               st_n = SHOW_ON;
               stp_n = '0;
               code_n = lvl == 4'd0 ? sym : mem[0];
            end
            SHOW_ON: st_n = tmr == ON_T ? SHOW_OFF : st;
            SHOW_OFF:
               if (tmr == OFF_T) begin
                  st_n = stp == lvl ? WAIT_IN : SHOW_ON;
                  stp_n = stp == lvl ? 4'd0 : stp_inc;
                  code_n = mem[stp_inc];
               end
            WAIT_IN:
               // a press wins over a simultaneous timeout
               if (bus.btn_valid) begin
                  if (bus.btn_code != mem[stp]) st_n = LOSE;
                  else if (stp < lvl) begin
                     stp_n = stp_inc;
                     tmr_n = '0;
                  end else if (lvl == LAST) st_n = WIN;
                  else begin
                     lvl_n = lvl + 4'd1;
                     st_n = GEN;
                  end
               end else if (tmr == TO_T) st_n = LOSE;
            default: ;
         endcase
      if (bus.start || st_n != st) tmr_n = '0;
      lamp_n = st_n == SHOW_ON;
      win_n = (win_q && !bus.start) || st_n == WIN;
      lose_n = (lose_q && !bus.start) || st_n == LOSE;
   end
   assign bus.state = st;
   assign bus.level = lvl;
   assign bus.step = stp;
   assign bus.lamp_on = lamp_q;
   assign bus.lamp_code = code_q;
   assign bus.win = win_q;
   assign bus.lose = lose_q;
endmodule

// File: tb/tb_genius_round_ctrl.sv
// tb_genius_round_ctrl: directed checks of playback timing, press evaluation, timeout, restart and reset
module tb_genius_round_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int bad = 0;
   genius_round_ctrl_if bus ();
   genius_round_ctrl #(
      .ON_CYCLES(4), .OFF_CYCLES(2), .TIMEOUT_CYCLES(20), .MAX_LEVEL(3)
   ) dut (
      .clock(clk), .reset(rst_n), .bus(bus.slave)
   );
   always #5 clk = ~clk;
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic go(input logic [7:0] s);
      bus.seed = s;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask
   task automatic press(input logic [1:0] c);
      bus.btn_valid = 1'b1;
      bus.btn_code = c;
      tick();
      bus.btn_valid = 1'b0;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.start = 1'b0;
      bus.seed = 8'h00;
      bus.btn_valid = 1'b0;
      bus.btn_code = 2'd0;
      tick(2);
      rst_n = 1'b1;
      tick();
      chk("rst_state", bus.state, 0);
      chk("rst_lamp", bus.lamp_on, 0);
      chk("rst_code", bus.lamp_code, 0);
      chk("rst_level", bus.level, 0);
      chk("rst_step", bus.step, 0);
      chk("rst_win", bus.win, 0);
      chk("rst_lose", bus.lose, 0);
      // seed 01 yields symbols 1, 2, 0
      go(8'h01);
      chk("start_gen", bus.state, 1);
      tick();
      chk("r1_on_state", bus.state, 2);
      chk("r1_on_lamp", bus.lamp_on, 1);
      chk("r1_on_code", bus.lamp_code, 1);
      tick(3);
      chk("r1_on_last", bus.state, 2);
      chk("r1_on_last_code", bus.lamp_code, 1);
      tick();
      chk("r1_off_state", bus.state, 3);
      chk("r1_off_lamp", bus.lamp_on, 0);
      chk("r1_off_code", bus.lamp_code, 0);
      tick();
      chk("r1_off_hold", bus.state, 3);
      tick();
      chk("r1_wait", bus.state, 4);
      chk("r1_wait_step", bus.step, 0);
      press(2'd1);
      chk("r1_ok_gen", bus.state, 1);
      chk("r1_ok_level", bus.level, 1);
      tick();
      chk("r2_on_state", bus.state, 2);
      chk("r2_on_code", bus.lamp_code, 1);
      press(2'd3);
      chk("ignore_state", bus.state, 2);
      chk("ignore_lose", bus.lose, 0);
      tick(4);
      chk("r2_off", bus.state, 3);
      tick(2);
      chk("r2_s1_state", bus.state, 2);
      chk("r2_s1_step", bus.step, 1);
      chk("r2_s1_code", bus.lamp_code, 2);
      tick(6);
      chk("r2_wait", bus.state, 4);
      chk("r2_wait_step", bus.step, 0);
      press(2'd1);
      chk("r2_p0_state", bus.state, 4);
      chk("r2_p0_step", bus.step, 1);
      press(2'd2);
      chk("r2_ok_gen", bus.state, 1);
      chk("r2_ok_level", bus.level, 2);
      tick();
      chk("r3_s0_code", bus.lamp_code, 1);
      tick(12);
      chk("r3_s2_state", bus.state, 2);
      chk("r3_s2_step", bus.step, 2);
      chk("r3_s2_lamp", bus.lamp_on, 1);
      chk("r3_s2_code", bus.lamp_code, 0);
      tick(6);
      chk("r3_wait", bus.state, 4);
      press(2'd1);
      press(2'd2);
      press(2'd0);
      chk("win_state", bus.state, 5);
      chk("win_flag", bus.win, 1);
      chk("win_level", bus.level, 2);
      tick();
      chk("win_hold", bus.state, 5);
      // wrong press at step 0 of round 2
      go(8'h01);
      chk("restart_win_clr", bus.win, 0);
      tick(7);
      chk("lz_wait", bus.state, 4);
      press(2'd1);
      tick(13);
      chk("lz_r2_wait", bus.state, 4);
      press(2'd3);
      chk("lose_state", bus.state, 6);
      chk("lose_flag", bus.lose, 1);
      chk("lose_win", bus.win, 0);
      // timeout with no press
      go(8'h01);
      chk("restart_lose_clr", bus.lose, 0);
      tick(7);
      tick(19);
      chk("to_pre", bus.state, 4);
      tick();
      chk("to_state", bus.state, 6);
      chk("to_lose", bus.lose, 1);
      // press on the expiry cycle counts as a press
      go(8'h01);
      tick(7);
      tick(19);
      press(2'd1);
      chk("exp_press_state", bus.state, 1);
      chk("exp_press_level", bus.level, 1);
      chk("exp_press_lose", bus.lose, 0);
      // restart during SHOW_OFF
      tick(5);
      chk("so_state", bus.state, 3);
      go(8'h01);
      chk("so_gen", bus.state, 1);
      chk("so_level", bus.level, 0);
      tick();
      chk("so_on_code", bus.lamp_code, 1);
      // asynchronous reset mid-SHOW_ON
      rst_n = 1'b0;
      #1;
      chk("arst_state", bus.state, 0);
      chk("arst_lamp", bus.lamp_on, 0);
      chk("arst_code", bus.lamp_code, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("arst_idle", bus.state, 0);
      chk("arst_level", bus.level, 0);
      // zero seed behaves as A5: symbols 1, 2, 1
      go(8'h00);
      tick(7);
      press(2'd1);
      tick(13);
      press(2'd1);
      press(2'd2);
      chk("z_level", bus.level, 2);
      tick(13);
      chk("z_s2_step", bus.step, 2);
      chk("z_s2_code", bus.lamp_code, 1);
      tick(6);
      press(2'd1);
      press(2'd2);
      press(2'd1);
      chk("z_win", bus.state, 5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
